// File: rtl/tx_dmac.sv
// tx_dmac: transmit-side DMA controller.
//
// Reads fixed-length AXI4 bursts from a DDR ring buffer and forwards every beat to the TX
// AXI-Stream FIFO. Host software deposits data into the ring and announces it with
// read_access_tick (four-phase handshake against read_access_tick_ack). The block tracks how
// many bytes are waiting in DDR, wraps the read address inside the ring, and pulses an underrun
// indication when the TX FIFO could take a burst but DDR holds less than one.
//
// Ports
//   aclk, aresetn                   clock, asynchronous active-low reset
//   read_enable                     level run request
//   read_base_address / ddr_size    ring placement (4 KiB aligned base, size multiple of burst)
//   read_burst_len / burst_count    beats per burst (1..256) and bursts per run
//   read_access_size_bytes / tick   host deposit size and its request; _tick_ack acknowledges
//   tx_fifo_space_ready             downstream can absorb one full burst
//   read_busy / read_active         FSM not idle / stream handshake this cycle
//   read_ddr_occupation             bytes deposited but not yet requested
//   read_total_burst_count          bursts completed since enable rose
//   read_current_burst_address      low 32 bits of the last issued ARADDR
//   read_rresp                      RRESP of the last beat of the last burst
//   read_underrun_ins / _count      starvation pulse and saturating event count
//   m_axi_ar* / m_axi_r*            AXI4 read address and data channels
//   m_axis_tx_*                     TX AXI-Stream (combinational pass-through of R)
module tx_dmac (
  input  logic         aclk,
  input  logic         aresetn,
  input  logic         read_enable,
  input  logic [47:0]  read_base_address,
  input  logic [31:0]  read_ddr_size,
  input  logic [8:0]   read_burst_len,
  input  logic [31:0]  read_burst_count,
  input  logic [16:0]  read_access_size_bytes,
  input  logic         read_access_tick,
  input  logic         tx_fifo_space_ready,
  output logic         read_busy,
  output logic         read_active,
  output logic         read_access_tick_ack,
  output logic [31:0]  read_ddr_occupation,
  output logic [31:0]  read_total_burst_count,
  output logic [31:0]  read_current_burst_address,
  output logic [1:0]   read_rresp,
  output logic         read_underrun_ins,
  output logic [7:0]   read_underrun_count,
  output logic [47:0]  m_axi_araddr,
  output logic [7:0]   m_axi_arlen,
  output logic         m_axi_arvalid,
  input  logic         m_axi_arready,
  input  logic [127:0] m_axi_rdata,
  input  logic [1:0]   m_axi_rresp,
  input  logic         m_axi_rlast,
  input  logic         m_axi_rvalid,
  output logic         m_axi_rready,
  output logic [127:0] m_axis_tx_tdata,
  output logic         m_axis_tx_tvalid,
  input  logic         m_axis_tx_tready,
  output logic         m_axis_tx_tlast
);

  typedef enum logic [1:0] {
    StIdle  = 2'd0,
    StCheck = 2'd1,
    StAr    = 2'd2,
    StR     = 2'd3
  } state_e;

  state_e      state_q, state_d;
  logic [47:0] araddr_q, araddr_d;
  logic        arvalid_q, arvalid_d;
  logic [31:0] cur_addr_q, cur_addr_d;
  logic [31:0] burst_cnt_q, burst_cnt_d;
  logic [31:0] total_q, total_d;
  logic [1:0]  rresp_q, rresp_d;
  logic [31:0] occ_q, occ_d;
  logic        ack_q, ack_d;
  logic        starve_q;
  logic        underrun_ins_q, underrun_ins_d;
  logic [7:0]  underrun_cnt_q, underrun_cnt_d;

  logic [12:0] burst_bytes;
  logic        has_data;
  logic        ar_hs;
  logic        r_beat;
  logic        r_last_beat;
  logic        more_bursts;
  logic [48:0] next_addr_sum;
  logic [48:0] ring_end;
  logic        starve;
  logic        tick_accept;
  logic [32:0] occ_after_tick;

  assign burst_bytes = {read_burst_len, 4'b0000};
  assign has_data    = occ_q >= {19'd0, burst_bytes};
  assign ar_hs       = (state_q == StAr) && arvalid_q && m_axi_arready;
  assign r_beat      = (state_q == StR) && m_axi_rvalid && m_axis_tx_tready;
  assign r_last_beat = r_beat && m_axi_rlast;
  assign more_bursts = ({1'b0, burst_cnt_q} + 33'd1) < {1'b0, read_burst_count};

  // 49-bit sums so the wrap compare cannot overflow at the top of the address space.
  assign next_addr_sum = {1'b0, araddr_q} + {36'd0, burst_bytes};
  assign ring_end      = {1'b0, read_base_address} + {17'd0, read_ddr_size};

  // Starvation: the FIFO wants a burst, DDR cannot supply one, and the run has already moved
  // data (so the initial wait for host data does not count).
  assign starve = (state_q == StCheck) && read_enable && tx_fifo_space_ready && !has_data &&
                  (total_q != 32'd0);

  assign occ_after_tick = {1'b0, occ_q} + {16'd0, read_access_size_bytes};
  assign tick_accept    = read_access_tick && !ack_q &&
                          (occ_after_tick <= {1'b0, read_ddr_size});

  // Main FSM next-state.
  always_comb begin
    state_d     = state_q;
    araddr_d    = araddr_q;
    arvalid_d   = arvalid_q;
    cur_addr_d  = cur_addr_q;
    burst_cnt_d = burst_cnt_q;
    total_d     = total_q;
    rresp_d     = rresp_q;
    unique case (state_q)
      StIdle: begin
        araddr_d    = read_base_address;
        burst_cnt_d = 32'd0;
        if (read_enable) begin
          state_d = StCheck;
        end else begin
          total_d = 32'd0;
        end
      end
      StCheck: begin
        if (!read_enable) begin
          state_d = StIdle;
        end else if (tx_fifo_space_ready && has_data) begin
          arvalid_d  = 1'b1;
          cur_addr_d = araddr_q[31:0];
          state_d    = StAr;
        end
      end
      StAr: begin
        if (ar_hs) begin
          arvalid_d = 1'b0;
          state_d   = StR;
          araddr_d  = (next_addr_sum >= ring_end) ? read_base_address : next_addr_sum[47:0];
        end
      end
      StR: begin
        // Enable is only sampled at rlast so a burst in flight always drains completely.
        if (r_last_beat) begin
          burst_cnt_d = burst_cnt_q + 32'd1;
          total_d     = total_q + 32'd1;
          rresp_d     = m_axi_rresp;
          if (more_bursts && read_enable && !m_axi_rresp[1]) begin
            state_d = StCheck;
          end else begin
            state_d = StIdle;
          end
        end
      end
      default: begin
        state_d   = StIdle;
        arvalid_d = 1'b0;
      end
    endcase
  end

  // Occupation, tick handshake and underrun bookkeeping.
  always_comb begin
    occ_d          = occ_q;
    ack_d          = ack_q;
    underrun_ins_d = 1'b0;
    underrun_cnt_d = underrun_cnt_q;

    // Deposit and burst request may coincide; apply both as one net update.
    if (tick_accept) begin
      occ_d = occ_d + {15'd0, read_access_size_bytes};
    end
    if (ar_hs) begin
      occ_d = occ_d - {19'd0, burst_bytes};
    end

    if (tick_accept) begin
      ack_d = 1'b1;
    end else if (!read_access_tick) begin
      ack_d = 1'b0;
    end

    if (starve && !starve_q) begin
      underrun_ins_d = 1'b1;
    end
    if ((state_q == StIdle) && !read_enable) begin
      underrun_cnt_d = 8'd0;
    end else if (underrun_ins_d && (underrun_cnt_q != 8'hff)) begin
      underrun_cnt_d = underrun_cnt_q + 8'd1;
    end
  end

  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      state_q        <= StIdle;
      araddr_q       <= 48'd0;
      arvalid_q      <= 1'b0;
      cur_addr_q     <= 32'd0;
      burst_cnt_q    <= 32'd0;
      total_q        <= 32'd0;
      rresp_q        <= 2'd0;
      occ_q          <= 32'd0;
      ack_q          <= 1'b0;
      starve_q       <= 1'b0;
      underrun_ins_q <= 1'b0;
      underrun_cnt_q <= 8'd0;
    end else begin
      state_q        <= state_d;
      araddr_q       <= araddr_d;
      arvalid_q      <= arvalid_d;
      cur_addr_q     <= cur_addr_d;
      burst_cnt_q    <= burst_cnt_d;
      total_q        <= total_d;
      rresp_q        <= rresp_d;
      occ_q          <= occ_d;
      ack_q          <= ack_d;
      starve_q       <= starve;
      underrun_ins_q <= underrun_ins_d;
      underrun_cnt_q <= underrun_cnt_d;
    end
  end

  assign m_axi_araddr  = araddr_q;
  assign m_axi_arlen   = 8'(read_burst_len - 9'd1);
  assign m_axi_arvalid = arvalid_q;

  // Zero-latency R -> stream pass-through, gated to the R state.
  assign m_axis_tx_tdata  = m_axi_rdata;
  assign m_axis_tx_tvalid = (state_q == StR) && m_axi_rvalid;
  assign m_axis_tx_tlast  = (state_q == StR) && m_axi_rlast;
  assign m_axi_rready     = (state_q == StR) && m_axis_tx_tready;

  assign read_busy                  = state_q != StIdle;
  assign read_active                = r_beat;
  assign read_access_tick_ack       = ack_q;
  assign read_ddr_occupation        = occ_q;
  assign read_total_burst_count     = total_q;
  assign read_current_burst_address = cur_addr_q;
  assign read_rresp                 = rresp_q;
  assign read_underrun_ins          = underrun_ins_q;
  assign read_underrun_count        = underrun_cnt_q;

endmodule

// File: doc/tx_dmac.md
# tx_dmac

Transmit-side DMA controller: reads fixed-length AXI4 bursts from a DDR ring buffer and forwards the beats to the TX AXI-Stream FIFO. It is the read-side counterpart of the RX DMA path. Host software deposits data into DDR and signals it with `read_access_tick`. The block tracks DDR occupation, wraps the read address inside the ring, and flags underruns when the TX FIFO is starved.

## Interface
Parameters: none. All widths are fixed.

- `aclk` in 1: single clock for all logic.
- `aresetn` in 1: reset, asynchronous assert, active-low.
- `read_enable` in 1: run request; level-sensitive.
- `read_base_address` in 48: ring base; 4 KiB-aligned.
- `read_ddr_size` in 32: ring size in bytes; a multiple of the burst size.
- `read_burst_len` in 9: beats per burst, 1..256.
- `read_burst_count` in 32: bursts per run.
- `read_access_size_bytes` in 17: bytes deposited per host tick.
- `read_access_tick` in 1: host-data-available request (level).
- `tx_fifo_space_ready` in 1: downstream FIFO can absorb one full burst.
- `read_busy` out 1: state ≠ IDLE.
- `read_active` out 1: stream handshake this cycle.
- `read_access_tick_ack` out 1: four-phase ack for `read_access_tick`.
- `read_ddr_occupation` out 32: bytes in DDR not yet read.
- `read_total_burst_count` out 32: bursts completed since enable rose.
- `read_current_burst_address` out 32: low 32 bits of the last issued ARADDR.
- `read_rresp` out 2: RRESP of the last beat.
- `read_underrun_ins` out 1: one-cycle pulse on underrun.
- `read_underrun_count` out 8: underrun events, saturating.
- `m_axi_araddr` out 48, `m_axi_arlen` out 8, `m_axi_arvalid` out 1, `m_axi_arready` in 1: AXI read address channel.
- `m_axi_rdata` in 128, `m_axi_rresp` in 2, `m_axi_rlast` in 1, `m_axi_rvalid` in 1, `m_axi_rready` out 1: AXI read data channel.
- `m_axis_tx_tdata` out 128, `m_axis_tx_tvalid` out 1, `m_axis_tx_tready` in 1, `m_axis_tx_tlast` out 1: TX stream.

## Operation

**Derived values**
- `burst_bytes` = `read_burst_len` × 16 (13 bits).
- `m_axi_arlen` = `read_burst_len` − 1, combinational.
- `has_data` = occupation ≥ `burst_bytes`.

**States**
- IDLE(0):
  - Load `m_axi_araddr` ← base and clear the per-run burst counter.
  - If enable is high, go to CHECK. Otherwise clear the total and underrun counters.
- CHECK(1):
  - If enable is low, go to IDLE.
  - Else if `tx_fifo_space_ready` && `has_data`: set `m_axi_arvalid`, latch `read_current_burst_address`, go to AR.
  - Else if `tx_fifo_space_ready` && !`has_data` && total > 0: this is a starvation condition.
- AR(2):
  - Hold ARVALID until ARREADY.
  - On the handshake: drop ARVALID and go to R.
  - Next address = araddr + `burst_bytes`. If that is ≥ base + `read_ddr_size`, the next address is base instead (ring wrap).
- R(3): data passes straight from the R channel to the stream:
  - `tdata` = `rdata`
  - `tvalid` = `rvalid`
  - `rready` = `tready`
  - `tlast` = `rlast`
  - On an accepted beat with `rlast`:
    - Increment the burst counter and total.
    - Latch `read_rresp`.
    - Go to CHECK if counter+1 < `read_burst_count` && enable && !`rresp[1]`; otherwise go to IDLE.
- Outside R, `rready` and `tvalid` are 0.
- Undefined state codes go to IDLE.

**Occupation**
- The access tick is accepted when `tick` && !`ack` && occupation + access ≤ `read_ddr_size`. Acceptance adds `read_access_size_bytes` and sets `ack`.
- `ack` clears once the tick falls.
- A tick that would overfill the ring stays pending; `ack` stays 0.
- The AR handshake subtracts `burst_bytes`.
- If both events land in the same cycle, the net change is applied.

**Underrun**
- `read_underrun_ins` pulses only on the rising edge of the starvation condition.
- `read_underrun_count` increments on each pulse and saturates at 255.

**Boundary behaviour**
- Enable dropped in AR or R: the current burst completes fully (all R beats drained), then the FSM goes to IDLE.
- Error RRESP (`rresp[1]` set): the burst's beats are still forwarded; the FSM goes to IDLE after `rlast`.
- Reset mid-burst:
  - All outputs return to reset values immediately.
  - The AXI slave is not drained; the interconnect is reset alongside.

## Timing
- Every registered output resets to 0, including `m_axi_araddr` and `read_current_burst_address`.
- `m_axi_arvalid` rises one cycle after CHECK sees both conditions true.
- Stream path latency is 0 cycles (combinational).
- Between bursts there is a minimum of 3 cycles of overhead: R→CHECK→AR plus the ARREADY wait.
- Occupation and `ack` update one cycle after their causing event.

## Test plan
- **Single run:** base 0x1000, len 16, count 4, size 0x10000; one tick of 1024 B.
  - Expect 4 AR at 0x1000, 0x1100, 0x1200, 0x1300, each with ARLEN 15.
  - Expect 64 stream beats with `tlast` on every 16th.
  - Expect occupation 0 and total 4 at the end.
- **Ring wrap:** size 512, len 16, count 3.
  - Expect addresses base, base+0x100, then base again.
- **Backpressure:** random `tready` and `rvalid` stalls.
  - Expect data order preserved, no beat lost or duplicated, and `rready` equal to `tready` inside R.
- **Underrun:** `tx_fifo_space_ready` high, occupation 0 after 1 burst.
  - Expect exactly one `read_underrun_ins` pulse and count 1.
  - A tick of 256 B then resumes reading.
- **Overfill and simultaneous events:**
  - Occupation 0xFF00, size 0x10000, tick of 512 B: expect `ack` held 0 until a burst is issued, then net occupation 0xFF00 − 0x100 + 0x200 = 0x10000.
  - Tick coincident with an AR handshake: expect a single net update.
- **Error response and reset:**
  - SLVERR on the last beat: expect `read_rresp` = 2, return to IDLE, remaining bursts skipped.
  - `aresetn` low mid-R: expect `busy`, `arvalid`, `rready`, and `tvalid` all 0 asynchronously.
